operand_fetch_unit: RTL and testbench



---
 rtl/operand_fetch_unit_if.sv | 61 ++++++
 rtl/operand_fetch_unit.sv | 137 +++++++++++++
 tb/tb_operand_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_unit_if.sv
// Bundle of issue, operand, writeback and register-bank signals for operand_fetch_unit.
// slave = the fetch unit's view, master = the surrounding scheduler/lanes/bank.
interface operand_fetch_unit_if #(
  parameter int LANES = 16,
  parameter int XLEN  = 64,
  parameter int AW    = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [AW-1:0]         req_rs0;
  logic [AW-1:0]         req_rs1;
  logic [AW-1:0]         req_rd;
  logic [1:0]            req_nsrc;
  logic                  req_wr;
  logic [LANES-1:0]      req_mask;

  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*XLEN-1:0] out_rs0_data;
  logic [LANES*XLEN-1:0] out_rs1_data;
  logic [AW-1:0]         out_rd;
  logic                  out_wr;
  logic [LANES-1:0]      out_mask;

  logic                  wb_valid;
  logic [AW-1:0]         wb_addr;
  logic [LANES-1:0]      wb_mask;
  logic [LANES*XLEN-1:0] wb_data;

  logic [LANES-1:0]      read_en_0;
  logic [LANES-1:0]      read_en_1;
  logic [AW-1:0]         raddr_0;
  logic [AW-1:0]         raddr_1;
  logic [LANES*XLEN-1:0] rdata_0;
  logic [LANES*XLEN-1:0] rdata_1;
  logic [LANES-1:0]      write_en;
  logic [AW-1:0]         waddr;
  logic [LANES*XLEN-1:0] wdata;

  modport slave (
    input  req_valid, req_rs0, req_rs1, req_rd, req_nsrc, req_wr, req_mask,
    output req_ready,
    output out_valid, out_rs0_data, out_rs1_data, out_rd, out_wr, out_mask,
    input  out_ready,
    input  wb_valid, wb_addr, wb_mask, wb_data,
    output read_en_0, read_en_1, raddr_0, raddr_1,
    input  rdata_0, rdata_1,
    output write_en, waddr, wdata
  );

  modport master (
    output req_valid, req_rs0, req_rs1, req_rd, req_nsrc, req_wr, req_mask,
    input  req_ready,
    input  out_valid, out_rs0_data, out_rs1_data, out_rd, out_wr, out_mask,
    output out_ready,
    output wb_valid, wb_addr, wb_mask, wb_data,
    input  read_en_0, read_en_1, raddr_0, raddr_1,
    output rdata_0, rdata_1,
    input  write_en, waddr, wdata
  );
endinterface

// File: rtl/operand_fetch_unit.sv
// SIMT operand fetch: scoreboarded issue into register_bank with a registered operand stage.
// Optional writeback-to-operand forwarding is compiled in with `define OFU_WB_BYPASS_EN.
module operand_fetch_unit #(
  parameter int LANES = 16,
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_fetch_unit_if.slave  bus
);

  logic [NREGS-1:0]      busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic [LANES*XLEN-1:0] out_rs0_q, out_rs0_d;
  logic [LANES*XLEN-1:0] out_rs1_q, out_rs1_d;
  logic [AW-1:0]         out_rd_q, out_rd_d;
  logic                  out_wr_q, out_wr_d;
  logic [LANES-1:0]      out_mask_q, out_mask_d;
  logic [AW-1:0]         raddr0_q, raddr0_d;
  logic [AW-1:0]         raddr1_q, raddr1_d;

  logic                  use_rs0, use_rs1;
  logic                  haz_rs0, haz_rs1, haz_rd, hazard;
  logic                  req_ready, fire;
  logic [LANES-1:0]      ren0, ren1;
  logic [XLEN-1:0]       lane0, lane1;
  logic [LANES*XLEN-1:0] cap_rs0, cap_rs1;

  always_comb begin
    use_rs0 = (bus.req_nsrc != 2'd0);
    use_rs1 = bus.req_nsrc[1];
    haz_rs0 = use_rs0 & busy_q[bus.req_rs0];
    haz_rs1 = use_rs1 & busy_q[bus.req_rs1];
`ifdef OFU_WB_BYPASS_EN
    // A source being written back this cycle is forwarded, so it no longer blocks.
    if (bus.wb_valid && (bus.wb_addr == bus.req_rs0)) haz_rs0 = 1'b0;
    if (bus.wb_valid && (bus.wb_addr == bus.req_rs1)) haz_rs1 = 1'b0;
`endif
    haz_rd    = bus.req_wr & busy_q[bus.req_rd];
    hazard    = haz_rs0 | haz_rs1 | haz_rd;
    req_ready = !hazard & (!out_valid_q | bus.out_ready);
    fire      = bus.req_valid & req_ready;
    ren0      = (fire && use_rs0) ? bus.req_mask : '0;
    ren1      = (fire && use_rs1) ? bus.req_mask : '0;
  end

  always_comb begin
    lane0   = '0;
    lane1   = '0;
    cap_rs0 = '0;
    cap_rs1 = '0;
    for (int i = 0; i < LANES; i++) begin
      lane0 = bus.rdata_0[XLEN*i +: XLEN];
      lane1 = bus.rdata_1[XLEN*i +: XLEN];
`ifdef OFU_WB_BYPASS_EN
      if (bus.wb_valid && bus.wb_mask[i] && (bus.wb_addr == bus.req_rs0))
        lane0 = bus.wb_data[XLEN*i +: XLEN];
      if (bus.wb_valid && bus.wb_mask[i] && (bus.wb_addr == bus.req_rs1))
        lane1 = bus.wb_data[XLEN*i +: XLEN];
`endif
      cap_rs0[XLEN*i +: XLEN] = ren0[i] ? lane0 : '0;
      cap_rs1[XLEN*i +: XLEN] = ren1[i] ? lane1 : '0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_rs0_d   = out_rs0_q;
    out_rs1_d   = out_rs1_q;
    out_rd_d    = out_rd_q;
    out_wr_d    = out_wr_q;
    out_mask_d  = out_mask_q;
    raddr0_d    = raddr0_q;
    raddr1_d    = raddr1_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_rs0_d   = cap_rs0;
      out_rs1_d   = cap_rs1;
      out_rd_d    = bus.req_rd;
      out_wr_d    = bus.req_wr;
      out_mask_d  = bus.req_mask;
      raddr0_d    = bus.req_rs0;
      raddr1_d    = bus.req_rs1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Set after clear so an issue claiming rd wins over a same-cycle writeback of rd.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid)         busy_d[bus.wb_addr] = 1'b0;
    if (fire && bus.req_wr)   busy_d[bus.req_rd]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_rs0_q   <= '0;
      out_rs1_q   <= '0;
      out_rd_q    <= '0;
      out_wr_q    <= 1'b0;
      out_mask_q  <= '0;
      raddr0_q    <= '0;
      raddr1_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_rs0_q   <= out_rs0_d;
      out_rs1_q   <= out_rs1_d;
      out_rd_q    <= out_rd_d;
      out_wr_q    <= out_wr_d;
      out_mask_q  <= out_mask_d;
      raddr0_q    <= raddr0_d;
      raddr1_q    <= raddr1_d;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rs0_data = out_rs0_q;
  assign bus.out_rs1_data = out_rs1_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_wr       = out_wr_q;
  assign bus.out_mask     = out_mask_q;
  assign bus.read_en_0    = ren0;
  assign bus.read_en_1    = ren1;
  assign bus.raddr_0      = fire ? bus.req_rs0 : raddr0_q;
  assign bus.raddr_1      = fire ? bus.req_rs1 : raddr1_q;
  assign bus.write_en     = bus.wb_valid ? bus.wb_mask : '0;
  assign bus.waddr        = bus.wb_addr;
  assign bus.wdata        = bus.wb_data;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit with a behavioural register bank.
// Expectations for the forwarding case follow `define OFU_WB_BYPASS_EN.
module tb_operand_fetch_unit;
  localparam int LANES = 16;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int W     = LANES*XLEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_fetch_unit_if #(.LANES(LANES), .XLEN(XLEN), .AW(AW)) bus();

  operand_fetch_unit #(.LANES(LANES), .XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [XLEN-1:0] pat(input int r, input int l);
    return 64'hC0DE_0000_0000_0000 | (64'(r) << 16) | 64'(l);
  endfunction

  function automatic logic [W-1:0] row(input int r, input logic [LANES-1:0] m);
    logic [W-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) if (m[l]) v[XLEN*l +: XLEN] = pat(r, l);
    return v;
  endfunction

  function automatic logic [W-1:0] fill(input logic [XLEN-1:0] d, input logic [LANES-1:0] m);
    logic [W-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) if (m[l]) v[XLEN*l +: XLEN] = d;
    return v;
  endfunction

  // Behavioural register_bank: preloaded with a per-register/per-lane pattern on reset.
  logic [XLEN-1:0] bank [NREGS][LANES];
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        for (int l = 0; l < LANES; l++) bank[r][l] <= pat(r, l);
    end else begin
      for (int l = 0; l < LANES; l++)
        if (bus.write_en[l]) bank[bus.waddr][l] <= bus.wdata[XLEN*l +: XLEN];
    end
  end

  always_comb begin
    bus.rdata_0 = '0;
    bus.rdata_1 = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.rdata_0[XLEN*l +: XLEN] = bank[bus.raddr_0][l];
      bus.rdata_1[XLEN*l +: XLEN] = bank[bus.raddr_1][l];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    int idx;
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      idx = 0;
      for (int l = LANES-1; l >= 0; l--)
        if (got[XLEN*l +: XLEN] !== exp[XLEN*l +: XLEN]) idx = l;
      $display("FAIL %s: lane %0d got %h expected %h", tag, idx,
               got[XLEN*idx +: XLEN], exp[XLEN*idx +: XLEN]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.wb_valid  = 1'b0;
  endtask

  task automatic req(input int rs0, input int rs1, input int rd, input int nsrc,
                     input logic wr, input logic [LANES-1:0] mask);
    bus.req_valid = 1'b1;
    bus.req_rs0   = AW'(rs0);
    bus.req_rs1   = AW'(rs1);
    bus.req_rd    = AW'(rd);
    bus.req_nsrc  = 2'(nsrc);
    bus.req_wr    = wr;
    bus.req_mask  = mask;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_rs0   = '0;
    bus.req_rs1   = '0;
    bus.req_rd    = '0;
    bus.req_nsrc  = '0;
    bus.req_wr    = 1'b0;
    bus.req_mask  = '0;
    bus.out_ready = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_mask   = '0;
    bus.wb_data   = '0;

    // Reset values
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_rs0", bus.out_rs0_data, 0);
    chk("rst_out_mask", bus.out_mask, 0);
    chk("rst_read_en_0", bus.read_en_0, 0);
    chk("rst_raddr_0", bus.raddr_0, 0);
    chk("rst_write_en", bus.write_en, 0);
    chk("rst_req_ready", bus.req_ready, 1);

    // Two-source full-mask fetch
    tick();
    req(3, 7, 0, 2, 1'b0, 16'hFFFF);
    #1;
    chk("f1_ready", bus.req_ready, 1);
    chk("f1_read_en_0", bus.read_en_0, 16'hFFFF);
    chk("f1_read_en_1", bus.read_en_1, 16'hFFFF);
    chk("f1_raddr_0", bus.raddr_0, 3);
    chk("f1_raddr_1", bus.raddr_1, 7);
    tick();
    idle();
    chk("f1_out_valid", bus.out_valid, 1);
    chk("f1_out_rs0", bus.out_rs0_data, row(3, 16'hFFFF));
    chk("f1_out_rs1", bus.out_rs1_data, row(7, 16'hFFFF));
    chk("f1_out_mask", bus.out_mask, 16'hFFFF);
    #1;
    chk("f1_raddr_hold", bus.raddr_0, 3);
    chk("f1_read_en_idle", bus.read_en_0, 0);
    tick();
    chk("f1_out_drop", bus.out_valid, 0);

    // Single source, partial mask
    req(4, 8, 0, 1, 1'b0, 16'h00F0);
    #1;
    chk("f2_read_en_0", bus.read_en_0, 16'h00F0);
    chk("f2_read_en_1", bus.read_en_1, 0);
    tick();
    idle();
    chk("f2_out_rs0", bus.out_rs0_data, row(4, 16'h00F0));
    chk("f2_out_rs1", bus.out_rs1_data, 0);

    // nsrc=3 behaves like 2
    req(1, 2, 0, 3, 1'b0, 16'h000F);
    #1;
    chk("f3_read_en_1", bus.read_en_1, 16'h000F);
    tick();
    idle();
    chk("f3_out_rs1", bus.out_rs1_data, row(2, 16'h000F));

    // RAW on r5 waiting for writeback
    req(0, 0, 5, 0, 1'b1, 16'hFFFF);
    #1;
    chk("raw_nsrc0_read_en", bus.read_en_0, 0);
    chk("raw_wr_ready", bus.req_ready, 1);
    tick();
    chk("raw_out_rd", bus.out_rd, 5);
    chk("raw_out_wr", bus.out_wr, 1);
    req(5, 0, 0, 1, 1'b0, 16'hFFFF);
    #1;
    chk("raw_stall0", bus.req_ready, 0);
    tick();
    chk("raw_stall1", bus.req_ready, 0);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd5;
    bus.wb_mask  = 16'hFFFF;
    bus.wb_data  = fill(64'hDEAD_BEEF_0000_0001, 16'hFFFF);
    #1;
    chk("raw_write_en", bus.write_en, 16'hFFFF);
    chk("raw_waddr", bus.waddr, 5);
`ifdef OFU_WB_BYPASS_EN
    chk("raw_wb_ready", bus.req_ready, 1);
    tick();
    idle();
`else
    chk("raw_wb_ready", bus.req_ready, 0);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("raw_after_wb_ready", bus.req_ready, 1);
    tick();
    idle();
`endif
    chk("raw_out_valid", bus.out_valid, 1);
    chk("raw_out_rs0", bus.out_rs0_data, fill(64'hDEAD_BEEF_0000_0001, 16'hFFFF));
    tick();

    // Backpressure: out_ready low for 4 cycles with a pending request
    bus.out_ready = 1'b0;
    req(10, 0, 0, 1, 1'b0, 16'hFFFF);
    #1;
    chk("bp_first_ready", bus.req_ready, 1);
    tick();
    req(11, 0, 0, 1, 1'b0, 16'hFFFF);
    chk("bp_out_valid", bus.out_valid, 1);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_stall_ready", bus.req_ready, 0);
      chk("bp_stall_rs0", bus.out_rs0_data, row(10, 16'hFFFF));
      chk("bp_stall_raddr", bus.raddr_0, 10);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.req_ready, 1);
    tick();
    idle();
    chk("bp_b2b_valid", bus.out_valid, 1);
    chk("bp_b2b_rs0", bus.out_rs0_data, row(11, 16'hFFFF));
    tick();
    chk("bp_drain", bus.out_valid, 0);

    // Writeback to idle r9 in the same cycle r9 is claimed
    req(0, 0, 9, 0, 1'b1, 16'hFFFF);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd9;
    bus.wb_mask  = 16'h00FF;
    bus.wb_data  = fill(64'h0000_0000_0000_1234, 16'hFFFF);
    #1;
    chk("sw_write_en", bus.write_en, 16'h00FF);
    chk("sw_wdata", bus.wdata, fill(64'h0000_0000_0000_1234, 16'hFFFF));
    chk("sw_ready", bus.req_ready, 1);
    tick();
    bus.wb_valid = 1'b0;
    req(9, 0, 0, 1, 1'b0, 16'hFFFF);
    #1;
    chk("sw_busy9_stall", bus.req_ready, 0);
    tick();
    idle();
    tick();

    // Reset with a held output and r2 busy
    bus.out_ready = 1'b0;
    req(0, 0, 2, 0, 1'b1, 16'hFFFF);
    #1;
    chk("mr_claim_ready", bus.req_ready, 1);
    tick();
    idle();
    chk("mr_held_valid", bus.out_valid, 1);
    chk("mr_held_rd", bus.out_rd, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_out_rd", bus.out_rd, 0);
    chk("mr_out_wr", bus.out_wr, 0);
    bus.out_ready = 1'b1;
    req(2, 9, 0, 2, 1'b0, 16'hFFFF);
    #1;
    chk("mr_ready", bus.req_ready, 1);
    tick();
    idle();
    chk("mr_out_rs0", bus.out_rs0_data, row(2, 16'hFFFF));
    chk("mr_out_rs1", bus.out_rs1_data, row(9, 16'hFFFF));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
